// File: rtl/uart_datagram_rx_pkg.sv
// Shared constants and types for the UART datagram receiver.
package uart_datagram_rx_pkg;

    localparam int MESSAGE_SIZE = 32;
    localparam int NBYTES = MESSAGE_SIZE / 8;
    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef logic [7:0] byte_t;

    typedef enum logic [1:0] {
        HUNT,
        PAYLOAD,
        CHECK
    } frame_state_t;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } byte_state_t;

endpackage

// File: rtl/uart_datagram_rx_if.sv
// Serial input plus datagram result bus of the receiver.
interface uart_datagram_rx_if;
    import uart_datagram_rx_pkg::*;

    logic                    RxD;
    logic [MESSAGE_SIZE-1:0] datagram;
    logic                    datagram_valid;
    logic                    frame_error;
    logic                    checksum_error;

    // Receiver side: consumes the line, produces datagrams.
    modport master (
        input  RxD,
        output datagram,
        output datagram_valid,
        output frame_error,
        output checksum_error
    );

    // Line driver / datagram consumer side.
    modport slave (
        output RxD,
        input  datagram,
        input  datagram_valid,
        input  frame_error,
        input  checksum_error
    );

endinterface

// File: rtl/uart_rx_byte.sv
// Oversampled 8N1 byte receiver: synchronizer, sample-tick divider, byte FSM.
module uart_rx_byte
    import uart_datagram_rx_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  rxd,
    output byte_t rx_byte,
    output logic  byte_valid,
    output logic  byte_ferr,
    output logic  line_idle,
    output logic  start_edge,
    output logic  sample_tick
);

    localparam int DIV    = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int TICK_W = $clog2(OVERSAMPLE) + 1;

    logic [1:0]        sync_reg;
    logic              rxd_prev_reg;
    logic              rxd_s;
    logic              fall_edge;
    logic [DIV_W-1:0]  div_reg;
    byte_state_t       state_reg, state_next;
    logic [TICK_W-1:0] tick_cnt_reg, tick_cnt_next;
    logic [2:0]        bit_cnt_reg, bit_cnt_next;
    byte_t             shift_reg, shift_next;
    logic              valid_reg, valid_next;
    logic              ferr_reg, ferr_next;

    assign rxd_s       = sync_reg[1];
    assign fall_edge   = rxd_prev_reg & ~rxd_s;
    assign sample_tick = (div_reg == DIV_W'(DIV - 1));
    assign line_idle   = (state_reg == IDLE);
    assign start_edge  = line_idle & fall_edge;
    assign rx_byte     = shift_reg;
    assign byte_valid  = valid_reg;
    assign byte_ferr   = ferr_reg;

    // Two-stage synchronizer plus previous-value register for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_reg     <= 2'b11;
            rxd_prev_reg <= 1'b1;
        end else begin
            sync_reg     <= {sync_reg[0], rxd};
            rxd_prev_reg <= sync_reg[1];
        end
    end

    // Free-running divider producing one sample tick every DIV clocks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)              div_reg <= '0;
        else if (sample_tick) div_reg <= '0;
        else                  div_reg <= div_reg + DIV_W'(1);
    end

    // Byte FSM state and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            tick_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            shift_reg    <= '0;
            valid_reg    <= 1'b0;
            ferr_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            tick_cnt_reg <= tick_cnt_next;
            bit_cnt_reg  <= bit_cnt_next;
            shift_reg    <= shift_next;
            valid_reg    <= valid_next;
            ferr_reg     <= ferr_next;
        end
    end

    // Next-state logic: mid-bit sampling, LSB first, stop-bit verdict as a pulse.
    always_comb begin
        state_next    = state_reg;
        tick_cnt_next = tick_cnt_reg;
        bit_cnt_next  = bit_cnt_reg;
        shift_next    = shift_reg;
        valid_next    = 1'b0;
        ferr_next     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (fall_edge) begin
                    state_next    = START;
                    tick_cnt_next = '0;
                end
            end
            START: begin
                if (sample_tick) begin
                    if (tick_cnt_reg == TICK_W'(OVERSAMPLE / 2 - 1)) begin
                        tick_cnt_next = '0;
                        bit_cnt_next  = '0;
                        // A line already back high is a glitch, not a start bit.
                        state_next    = rxd_s ? IDLE : DATA;
                    end else begin
                        tick_cnt_next = tick_cnt_reg + TICK_W'(1);
                    end
                end
            end
            DATA: begin
                if (sample_tick) begin
                    if (tick_cnt_reg == TICK_W'(OVERSAMPLE - 1)) begin
                        tick_cnt_next = '0;
                        shift_next    = {rxd_s, shift_reg[7:1]};
                        if (bit_cnt_reg == 3'd7) state_next   = STOP;
                        else                     bit_cnt_next = bit_cnt_reg + 3'd1;
                    end else begin
                        tick_cnt_next = tick_cnt_reg + TICK_W'(1);
                    end
                end
            end
            STOP: begin
                if (sample_tick) begin
                    if (tick_cnt_reg == TICK_W'(OVERSAMPLE - 1)) begin
                        tick_cnt_next = '0;
                        state_next    = IDLE;
                        valid_next    = rxd_s;
                        ferr_next     = ~rxd_s;
                    end else begin
                        tick_cnt_next = tick_cnt_reg + TICK_W'(1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: rtl/uart_datagram_rx.sv
// Frame sync, payload assembly and XOR checksum check on top of the byte receiver.
module uart_datagram_rx
    import uart_datagram_rx_pkg::*;
#(
    parameter int CLK_FREQ     = 100_000_000,
    parameter int BAUD         = 115200,
    parameter int OVERSAMPLE   = 16,
    parameter int TIMEOUT_BITS = 20
) (
    input logic              clk,
    input logic              rst,
    uart_datagram_rx_if.master bus
);

    localparam int TIMEOUT_TICKS = TIMEOUT_BITS * OVERSAMPLE;
    localparam int TO_W          = $clog2(TIMEOUT_TICKS + 1);
    localparam int IDX_W         = $clog2(NBYTES) + 1;

    byte_t                   rx_byte;
    logic                    byte_valid, byte_ferr, line_idle, start_edge, sample_tick;
    frame_state_t            state_reg, state_next;
    logic [IDX_W-1:0]        idx_reg, idx_next;
    byte_t                   csum_reg, csum_next;
    logic [TO_W-1:0]         to_cnt_reg, to_cnt_next;
    logic [MESSAGE_SIZE-1:0] dg_reg, dg_next;
    logic                    valid_reg, valid_next;
    logic                    ferr_reg, ferr_next;
    logic                    cerr_reg, cerr_next;
    logic                    load_payload;
    logic                    timeout_hit;
    byte_t                   hold_reg [NBYTES];
    logic [MESSAGE_SIZE-1:0] hold_flat;

    uart_rx_byte #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .OVERSAMPLE (OVERSAMPLE)
    ) u_byte (
        .clk         (clk),
        .rst         (rst),
        .rxd         (bus.RxD),
        .rx_byte     (rx_byte),
        .byte_valid  (byte_valid),
        .byte_ferr   (byte_ferr),
        .line_idle   (line_idle),
        .start_edge  (start_edge),
        .sample_tick (sample_tick)
    );

    assign timeout_hit = (state_reg != HUNT) && line_idle && sample_tick && !start_edge
                         && (to_cnt_reg == TO_W'(TIMEOUT_TICKS - 1));

    // Payload lanes: byte idx lands in lane idx; lane 0 is the datagram MSB byte.
    for (genvar gi = 0; gi < NBYTES; gi++) begin : g_lane
        // Capture the payload byte addressed to this lane.
        always_ff @(posedge clk or posedge rst) begin
            if (rst)                                         hold_reg[gi] <= '0;
            else if (load_payload && idx_reg == IDX_W'(gi)) hold_reg[gi] <= rx_byte;
        end
        assign hold_flat[(NBYTES - 1 - gi) * 8 +: 8] = hold_reg[gi];
    end

    // Frame FSM state, counters and output strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= HUNT;
            idx_reg    <= '0;
            csum_reg   <= '0;
            to_cnt_reg <= '0;
            dg_reg     <= '0;
            valid_reg  <= 1'b0;
            ferr_reg   <= 1'b0;
            cerr_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            idx_reg    <= idx_next;
            csum_reg   <= csum_next;
            to_cnt_reg <= to_cnt_next;
            dg_reg     <= dg_next;
            valid_reg  <= valid_next;
            ferr_reg   <= ferr_next;
            cerr_reg   <= cerr_next;
        end
    end

    // Frame next-state logic; the if/else chain keeps the three strobes exclusive.
    always_comb begin
        state_next   = state_reg;
        idx_next     = idx_reg;
        csum_next    = csum_reg;
        dg_next      = dg_reg;
        valid_next   = 1'b0;
        ferr_next    = 1'b0;
        cerr_next    = 1'b0;
        load_payload = 1'b0;
        to_cnt_next  = to_cnt_reg;
        if (state_reg == HUNT || start_edge)  to_cnt_next = '0;
        else if (line_idle && sample_tick)    to_cnt_next = to_cnt_reg + TO_W'(1);

        if (byte_ferr) begin
            ferr_next  = 1'b1;
            state_next = HUNT;
        end else if (timeout_hit) begin
            ferr_next   = 1'b1;
            state_next  = HUNT;
            to_cnt_next = '0;
        end else if (byte_valid) begin
            case (state_reg)
                HUNT: begin
                    if (rx_byte == SYNC_BYTE) begin
                        state_next = PAYLOAD;
                        idx_next   = '0;
                        csum_next  = '0;
                    end
                end
                PAYLOAD: begin
                    load_payload = 1'b1;
                    csum_next    = csum_reg ^ rx_byte;
                    idx_next     = idx_reg + IDX_W'(1);
                    if (idx_reg == IDX_W'(NBYTES - 1)) state_next = CHECK;
                end
                CHECK: begin
                    if (rx_byte == csum_reg) begin
                        dg_next    = hold_flat;
                        valid_next = 1'b1;
                    end else begin
                        cerr_next  = 1'b1;
                    end
                    state_next = HUNT;
                end
                default: state_next = HUNT;
            endcase
        end
    end

    assign bus.datagram       = dg_reg;
    assign bus.datagram_valid = valid_reg;
    assign bus.frame_error    = ferr_reg;
    assign bus.checksum_error = cerr_reg;

endmodule
